// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum byte is enabled by defining IMEM_LOADER_CSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CSUM
    } state_e;

    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam logic [15:0] LEN_EMPTY     = 16'h0000;

    function automatic logic len_too_big(input logic [15:0] n, input int aw);
        return 32'(n) > (32'd1 << aw);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction store: synchronous write, asynchronous read.
// The CPU samples insn one cycle after pc changes, so the read is combinational.
module imem_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [15:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [15:0]       rdata_o
);

    logic [15:0] mem [2**ADDR_W];

    // write port; contents are never reset
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader in front of the instruction RAM.
// Define IMEM_LOADER_CSUM_EN to require a trailing 8-bit checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc,
    output logic [15:0]       insn,
    output logic              cpu_rst,
    output logic              load_busy,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   WORDS_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic              we;
    logic [15:0]       len_in;
    logic              last_word;

    assign len_in    = {len_q[15:8], in_data};
    assign last_word = (17'(words_q) + 17'd1) == {1'b0, len_q};

    // next-state and datapath updates; only an accepted byte moves anything
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        hi_d      = hi_q;
        addr_d    = addr_q;
        words_d   = words_q;
        cpu_rst_d = cpu_rst_q;
        busy_d    = busy_q;
        err_d     = err_q;
        we        = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
        sum_d     = sum_q;
`endif
        if (in_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_data == SYNC_BYTE) begin
                        state_d   = ST_LEN_HI;
                        cpu_rst_d = 1'b1;
                        busy_d    = 1'b1;
                        err_d     = 1'b0;
                        words_d   = '0;
                        addr_d    = '0;
`ifdef IMEM_LOADER_CSUM_EN
                        sum_d     = '0;
`endif
                    end
                end
                ST_LEN_HI: begin
                    len_d[15:8] = in_data;
                    state_d     = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    len_d[7:0] = in_data;
                    if (len_too_big(len_in, ADDR_W)) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else if (len_in == LEN_EMPTY) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state_d   = ST_CSUM;
`else
                        state_d   = ST_IDLE;
                        cpu_rst_d = 1'b0;
                        busy_d    = 1'b0;
`endif
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
                ST_DATA_HI: begin
                    hi_d    = in_data;
                    state_d = ST_DATA_LO;
`ifdef IMEM_LOADER_CSUM_EN
                    sum_d   = sum_q + in_data;
`endif
                end
                ST_DATA_LO: begin
                    we      = 1'b1;
                    addr_d  = addr_q + ADDR_ONE;
                    words_d = words_q + WORDS_ONE;
`ifdef IMEM_LOADER_CSUM_EN
                    sum_d   = sum_q + in_data;
                    state_d = last_word ? ST_CSUM : ST_DATA_HI;
`else
                    if (last_word) begin
                        state_d   = ST_IDLE;
                        cpu_rst_d = 1'b0;
                        busy_d    = 1'b0;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
`endif
                end
`ifdef IMEM_LOADER_CSUM_EN
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (in_data == sum_q) cpu_rst_d = 1'b0;
                    else                  err_d     = 1'b1;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // state and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            hi_q      <= '0;
            addr_q    <= '0;
            words_q   <= '0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            hi_q      <= hi_d;
            addr_q    <= addr_d;
            words_q   <= words_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
`ifdef IMEM_LOADER_CSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    imem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (addr_q),
        .wdata_i ({hi_q, in_data}),
        .raddr_i (pc),
        .rdata_o (insn)
    );

    assign in_ready     = 1'b1;
    assign cpu_rst      = cpu_rst_q;
    assign load_busy    = busy_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction memory for the stack CPU, plus a byte-stream loader that writes programs into it.
- It serves `insn` to the CPU for the CPU's `pc` and holds the CPU in reset until a complete, valid program frame has been written.
- Byte source is upstream, e.g. a UART receiver, over a valid/ready handshake.

Parameters:
- ADDR_W, 10, instruction address width; depth = 2**ADDR_W words of 16 bits.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- in_data  input  8  loader byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts byte; transfer = in_valid & in_ready
- pc  input  ADDR_W  CPU fetch address
- insn  output  16  instruction at pc
- cpu_rst  output  1  reset to CPU; high while no valid program is loaded
- load_busy  output  1  frame in progress
- load_err  output  1  last frame rejected (sticky until next sync)
- words_loaded  output  ADDR_W+1  words written by current/last frame

Behaviour:
- Reset values: cpu_rst=1, load_busy=0, load_err=0, words_loaded=0, state IDLE. in_ready is 1 in every state.
- Memory contents are not reset; unwritten words are undefined.
- insn = mem[pc], combinational (async read).
  - The CPU samples insn in the cycle after pc changes, so registered read is forbidden.
- Frame format, in order:
  - SYNC_BYTE
  - LEN_HI, LEN_LO: 16-bit word count N
  - N words, each sent hi byte then lo byte, big-endian
  - CSUM: 8-bit wraparound sum of all data bytes
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM.
  - All transitions occur only on an accepted byte, except reset.
- IDLE:
  - A byte equal to SYNC_BYTE goes to LEN_HI. In the same edge: cpu_rst<=1, load_busy<=1, load_err<=0, words_loaded<=0, write address<=0, sum<=0.
  - Any other byte is dropped; cpu_rst and flags are unchanged.
- LEN_HI: latch the high byte of N, go to LEN_LO.
- LEN_LO:
  - If N > 2**ADDR_W: go to IDLE with load_err<=1, load_busy<=0, cpu_rst stays 1.
  - Else if N==0: go to CSUM.
  - Else: go to DATA_HI.
- DATA_HI: latch hi byte, sum += byte, go to DATA_LO.
- DATA_LO:
  - Write mem[addr] <= {hi, byte} on this edge; addr++, words_loaded++, sum += byte.
  - If words_loaded+1 == N, go to CSUM; else go to DATA_HI.
- CSUM:
  - If byte == sum: go to IDLE, cpu_rst<=0, load_busy<=0. The CPU runs from the next cycle.
  - Else: go to IDLE, load_err<=1, load_busy<=0, cpu_rst stays 1.
- A SYNC_BYTE value inside a frame is treated as ordinary data; there is no resynchronisation mid-frame.
- A new SYNC after a successful load re-asserts cpu_rst on the next edge and reloads from address 0.
- Words written by an aborted or failed frame remain in memory; cpu_rst protects the CPU from them.
- Asynchronous rst mid-frame:
  - State returns to IDLE with cpu_rst=1 and counters cleared.
  - A write on that edge is not guaranteed.
- Address wrap cannot occur because N ≤ depth is checked at LEN_LO.

Optional Feature:
- IMEM_LOADER_CSUM_EN defined: the CSUM byte is part of the frame, as above.
- Undefined: no CSUM state or byte.
  - After the last DATA_LO (or at LEN_LO when N==0): go to IDLE, cpu_rst<=0, load_busy<=0.
  - The sum register is removed.
  - load_err is set only for oversize N.

Decomposition:
- Package imem_loader_pkg: state enum, SYNC_BYTE default, frame byte constants.
- Sub-module imem_ram: 2**ADDR_W x 16, synchronous write port, asynchronous read port.

Test Plan:
- Good load: send A5 00 02 01 05 01 02 09 -> cpu_rst falls after the 09 byte; words_loaded=2; insn=0x0105 at pc=0 and 0x0102 at pc=1; load_err=0.
- Bad checksum: same frame with last byte 0A -> load_err=1, cpu_rst stays 1, load_busy=0, insn at pc=0 is 0x0105.
- Oversize: A5 04 01 -> load_err=1 after LEN_LO; the next bytes 00 00 are dropped in IDLE; cpu_rst=1.
- Garbage then sync: 00 FF 12 followed by a good frame -> garbage ignored, load succeeds; with macro undefined, frame A5 00 01 12 34 -> insn=0x1234, cpu_rst=0.
- Zero length: A5 00 00 00 -> cpu_rst=0, words_loaded=0, load_err=0.
- Reset mid-frame: rst pulse after the DATA_HI byte -> IDLE, cpu_rst=1, words_loaded=0, load_busy=0. Then reload after a successful run: A5 -> cpu_rst=1 on the next edge.
